mem_responder: RTL and testbench
================================

# mem_responder

Multi-cycle data-memory responder that answers the CPU-side `ren`/`wen`/`addr`/`din` request interface with a registered `dout`, a one-cycle `ready` pulse and an `err` flag. It replaces the zero-latency combinational memory model when the datapath is moved to a stalling, handshake-driven memory port. It holds a word-addressed array and inserts a programmable number of wait states per access. It also detects illegal requests.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: wait states inserted between request capture and the array access (0 allowed).
- `ADDR_BITS`, 10: word-index width; the array holds 2^ADDR_BITS 32-bit words.
- `PROT_WORDS`, 256: number of write-protected low words; used only with `MEM_WRITE_PROTECT_EN`.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `ren`  in  1: read request.
- `wen`  in  1: write request.
- `addr`  in  32: word index; only `addr[ADDR_BITS-1:0]` selects the word.
- `din`  in  32: write data.
- `dout`  out  32: registered read data. Valid while `ready`=1 for a read.
- `ready`  out  1: one-cycle completion pulse.
- `err`  out  1: error qualifier. Meaningful only while `ready`=1.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If `ren|wen`=1 at a rising edge, latch `ren`, `wen`, `addr` and `din` into holding registers.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT, or to ACCESS directly if `WAIT_CYCLES`=0.
- WAIT: decrement the counter each edge. At count 1, go to ACCESS.
- ACCESS: act on the latched operation at the edge leaving ACCESS, then go to RESP.
  - Read: `dout` <= `mem[addr_q[ADDR_BITS-1:0]]`.
  - Write: `mem[...]` <= `din_q`. `dout` is unchanged.
- RESP: `ready`=1 for exactly one cycle, then return to IDLE unconditionally.
- Requests arriving in WAIT, ACCESS or RESP are ignored. The requester drops `ren`/`wen` on seeing `ready`. A request still asserted on the first IDLE cycle after RESP is treated as a new request.
- Inputs may change freely after the capture edge, because operands are latched.
- Error cases (`err`=1 together with `ready`):
  - `ren`=`wen`=1 at capture: request rejected. No write, `dout` unchanged.
  - `addr[31:ADDR_BITS]` != 0: the access is still performed on the low bits (wrap-around).
- Array contents are not reset and are X until written.

## Timing
- Reset (async assert) values: state IDLE, `ready`=0, `err`=0, `dout`=0, counter 0, holding registers 0.
- Latency: with capture at edge E0, `ready` is high in the cycle following edge E0+`WAIT_CYCLES`+1.
  - `WAIT_CYCLES`=0: `ready` is high after E1.
  - Default: `ready` is high after E3.
- Throughput: one access per `WAIT_CYCLES`+3 cycles when the requester re-requests immediately (capture, wait, access, resp, idle).
- Reset asserted mid-operation: the FSM aborts immediately.
  - A write not yet committed at the ACCESS edge is lost.
  - A committed write remains in the array.
- Reset deassertion: the first capture is possible at the first rising edge with `reset`=1.
- Back-to-back read after write to the same word returns the new data.

## Configuration
- `MEM_WRITE_PROTECT_EN` defined: writes with `addr[ADDR_BITS-1:0]` < `PROT_WORDS` do not modify the array and complete with `err`=1. Reads of that range are unaffected.
- `MEM_WRITE_PROTECT_EN` undefined: all words are writable, `PROT_WORDS` is ignored, and no protection logic is built.

## Test plan
- Reset, then write `addr`=0x120 (word 0x120 > `PROT_WORDS`), `din`=0xDEADBEEF, followed by a read of `addr`=0x120.
  - Expect `ready` 3 cycles after each capture, `err`=0.
  - Expect `dout`=0xDEADBEEF on the read `ready`.
- `WAIT_CYCLES`=0: read of a previously written word.
  - Expect `ready` in the cycle after E1 and correct `dout`.
  - Expect the second request ignored until IDLE.
- `ren`=`wen`=1, `addr`=0x300, `din`=0x5.
  - Expect `ready`=1 with `err`=1.
  - Expect a subsequent read of 0x300 to return the prior contents, not 0x5.
- `addr`=0x00000404, `din`=0xA5A5A5A5 with write, then read `addr`=0x4.
  - Expect `err`=1 on the write `ready`.
  - Expect the read to return 0xA5A5A5A5 with `err`=0.
- Capture a write, then assert `reset` low in WAIT.
  - Expect `ready`/`err`/`dout`=0 immediately and the target word unchanged.
- With `MEM_WRITE_PROTECT_EN`: write 0x10 <= 0x1234.
  - Expect `err`=1 and a read of 0x10 unchanged.
  - Without the macro: `err`=0 and a read returns 0x1234.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-cycle word memory responder with wait states and error flagging
// Optional build macro: MEM_WRITE_PROTECT_EN (write-protects the lowest PROT_WORDS words)
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 10,
    parameter int PROT_WORDS  = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        err
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ren_q, ren_d;
    logic                   wen_q, wen_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            din_q, din_d;
    logic [31:0]            dout_q, dout_d;
    logic                   err_q, err_d;
    logic                   mem_we;
    logic                   prot_in;
    logic                   prot_hold;

    logic [31:0] mem [2**ADDR_BITS];

`ifdef MEM_WRITE_PROTECT_EN
    localparam logic [ADDR_BITS:0] PROT_LIM = (ADDR_BITS + 1)'(PROT_WORDS);

    // A protected write is flagged at capture and suppressed again at the access edge.
    assign prot_in   = wen & ~ren & ({1'b0, addr[ADDR_BITS-1:0]} < PROT_LIM);
    assign prot_hold = {1'b0, addr_q} < PROT_LIM;
`else
    assign prot_in   = 1'b0;
    assign prot_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ren | wen) begin
                    ren_d   = ren;
                    wen_d   = wen;
                    addr_d  = addr[ADDR_BITS-1:0];
                    din_d   = din;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    err_d   = (ren & wen) | (|addr[31:ADDR_BITS]) | prot_in;
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Out-of-range high address bits still access the wrapped word.
                if (ren_q & ~wen_q) begin
                    dout_d = mem[addr_q];
                end else if (wen_q & ~ren_q & ~prot_hold) begin
                    mem_we = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; a write only lands on the ACCESS edge.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= din_q;
        end
    end

    assign dout  = dout_q;
    assign ready = (state_q == S_RESP);
    assign err   = (state_q == S_RESP) & err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder (WAIT_CYCLES 2 and 0)
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ren, wen, ready, err;
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [int];
    logic [31:0] last_dout [2];
    bit          dout_known [2];
    int          wq0 [$];
    int          wq1 [$];

    always #5 clock = ~clock;

    mem_responder #(.WAIT_CYCLES(2), .ADDR_BITS(10), .PROT_WORDS(256)) u0 (
        .clock(clock), .reset(reset), .ren(ren[0]), .wen(wen[0]), .addr(addr[0]),
        .din(din[0]), .dout(dout[0]), .ready(ready[0]), .err(err[0])
    );

    mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(10), .PROT_WORDS(256)) u1 (
        .clock(clock), .reset(reset), .ren(ren[1]), .wen(wen[1]), .addr(addr[1]),
        .din(din[1]), .dout(dout[1]), .ready(ready[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit prot_hit(input bit r, input bit w, input int idx);
`ifdef MEM_WRITE_PROTECT_EN
        return w && !r && (idx < 256);
`else
        return 1'b0;
`endif
    endfunction

    // One complete request: drive, capture, scramble inputs while busy, wait for ready, drop.
    task automatic do_access(input int u, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] d);
        int  lat;
        int  wc;
        int  idx;
        int  key;
        bit  e;
        bit  do_op;
        wc    = (u == 0) ? 2 : 0;
        idx   = int'(a[9:0]);
        key   = u * 4096 + idx;
        e     = (r && w) || (a[31:10] != 22'd0) || prot_hit(r, w, idx);
        do_op = !(r && w) && !prot_hit(r, w, idx);
        @(negedge clock);
        ren[u] = r; wen[u] = w; addr[u] = a; din[u] = d;
        @(posedge clock);
        #1;
        lat = 0;
        if (wc > 0) begin
            @(negedge clock);
            ren[u] = 1'b1; wen[u] = 1'($urandom); addr[u] = $urandom; din[u] = $urandom;
        end
        while (ready[u] !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
            if (ready[u] !== 1'b1) begin
                ren[u] = 1'b1; wen[u] = 1'($urandom); addr[u] = $urandom; din[u] = $urandom;
            end
        end
        check($sformatf("lat_u%0d", u), lat, wc + 1);
        check($sformatf("err_u%0d", u), {31'd0, err[u]}, {31'd0, e});
        if (do_op && w) begin
            mdl[key] = d;
            if (u == 0) wq0.push_back(idx); else wq1.push_back(idx);
        end
        if (do_op && r) begin
            if (mdl.exists(key)) begin
                last_dout[u]  = mdl[key];
                dout_known[u] = 1'b1;
            end else begin
                dout_known[u] = 1'b0;
            end
        end
        if (dout_known[u]) check($sformatf("dout_u%0d", u), dout[u], last_dout[u]);
        @(negedge clock);
        ren[u] = 1'b0; wen[u] = 1'b0;
        @(posedge clock);
        #1;
        check($sformatf("pulse_u%0d", u), {31'd0, ready[u]}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          u;
        int          idx;
        int          sel;
        ren = '0; wen = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; din[i] = '0; last_dout[i] = '0; dout_known[i] = 1'b1;
        end
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", {31'd0, ready[i]}, 32'd0);
            check("rst_err", {31'd0, err[i]}, 32'd0);
            check("rst_dout", dout[i], 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;

        do_access(0, 1'b0, 1'b1, 32'h120, 32'hDEADBEEF);
        do_access(0, 1'b1, 1'b0, 32'h120, 32'h0);
        do_access(1, 1'b0, 1'b1, 32'h55, 32'h13572468);
        do_access(1, 1'b1, 1'b0, 32'h55, 32'h0);
        do_access(0, 1'b0, 1'b1, 32'h300, 32'h11112222);
        do_access(0, 1'b1, 1'b1, 32'h300, 32'h5);
        do_access(0, 1'b1, 1'b0, 32'h300, 32'h0);
        do_access(0, 1'b0, 1'b1, 32'h404, 32'hA5A5A5A5);
        do_access(0, 1'b1, 1'b0, 32'h4, 32'h0);
        do_access(0, 1'b0, 1'b1, 32'h10, 32'h1234);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Reset while the write to 0x120 is still waiting: the write must be lost.
        @(negedge clock);
        ren[0] = 1'b0; wen[0] = 1'b1; addr[0] = 32'h120; din[0] = 32'h0BADF00D;
        @(posedge clock);
        @(negedge clock);
        wen[0] = 1'b0;
        reset  = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ready[0]}, 32'd0);
        check("midrst_err", {31'd0, err[0]}, 32'd0);
        check("midrst_dout", dout[0], 32'd0);
        last_dout[0] = '0; last_dout[1] = '0;
        dout_known[0] = 1'b1; dout_known[1] = 1'b1;
        #2;
        reset = 1'b1;
        do_access(0, 1'b1, 1'b0, 32'h120, 32'h0);

        for (int n = 0; n < 60; n++) begin
            u   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, 1023));
            a   = {22'd0, 10'(idx)};
            if ($urandom_range(0, 3) == 0) a[31:10] = 22'($urandom_range(1, 7));
            if (sel < 4) begin
                do_access(u, 1'b0, 1'b1, a, $urandom);
            end else if (sel == 4) begin
                do_access(u, 1'b1, 1'b1, a, $urandom);
            end else if ((u == 0 && wq0.size() > 0) || (u == 1 && wq1.size() > 0)) begin
                if (u == 0) idx = wq0[$urandom_range(0, wq0.size() - 1)];
                else        idx = wq1[$urandom_range(0, wq1.size() - 1)];
                a[9:0] = 10'(idx);
                do_access(u, 1'b1, 1'b0, a, 32'h0);
            end else begin
                do_access(u, 1'b0, 1'b1, a, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
